// File: rtl/axi_rd_arbiter_if.sv
// Read-path bundle around axi_rd_arbiter: flattened master-side AR/R buses plus the single slave port.
// Modports: arb (the arbiter), master (the N upstream masters), slave (the downstream slave).
interface axi_rd_arbiter_if #(
    parameter int NM        = 2,
    parameter int IDM_BITS  = 4,
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
);
    // master side, master k in slice k
    logic [NM*IDM_BITS-1:0]  ARID_M;
    logic [NM*ADDR_BITS-1:0] ARADDR_M;
    logic [NM*LEN_BITS-1:0]  ARLEN_M;
    logic [NM*3-1:0]         ARSIZE_M;
    logic [NM*2-1:0]         ARBURST_M;
    logic [NM-1:0]           ARVALID_M;
    logic [NM-1:0]           ARREADY_M;
    logic [NM*IDM_BITS-1:0]  RID_M;
    logic [NM*DATA_BITS-1:0] RDATA_M;
    logic [NM*2-1:0]         RRESP_M;
    logic [NM-1:0]           RLAST_M;
    logic [NM-1:0]           RVALID_M;
    logic [NM-1:0]           RREADY_M;

    // slave side
    logic [IDS_BITS-1:0]     ARID_S;
    logic [ADDR_BITS-1:0]    ARADDR_S;
    logic [LEN_BITS-1:0]     ARLEN_S;
    logic [2:0]              ARSIZE_S;
    logic [1:0]              ARBURST_S;
    logic                    ARVALID_S;
    logic                    ARREADY_S;
    logic [IDS_BITS-1:0]     RID_S;
    logic [DATA_BITS-1:0]    RDATA_S;
    logic [1:0]              RRESP_S;
    logic                    RLAST_S;
    logic                    RVALID_S;
    logic                    RREADY_S;

    modport arb (
        input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
        output ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );

    modport master (
        output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
        input  ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
    );

    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// N-master to one-slave AXI read arbiter: round-robin on AR, grant held for the whole R burst.
// Define ARB_TIMEOUT_EN to add the stalled-burst watchdog that answers with a single SLVERR beat.
module axi_rd_arbiter_lane #(
    parameter int IDM_BITS  = 4,
    parameter int DATA_BITS = 32
) (
    input  logic                 sel_ar,
    input  logic                 sel_r,
    input  logic                 sel_err,
    input  logic                 arready_s,
    input  logic                 rvalid_s,
    input  logic [IDM_BITS-1:0]  rid_s,
    input  logic [DATA_BITS-1:0] rdata_s,
    input  logic [1:0]           rresp_s,
    input  logic                 rlast_s,
    input  logic [IDM_BITS-1:0]  err_id,
    output logic                 arready,
    output logic                 rvalid,
    output logic [IDM_BITS-1:0]  rid,
    output logic [DATA_BITS-1:0] rdata,
    output logic [1:0]           rresp,
    output logic                 rlast
);
    // Everything is forced to zero unless this lane owns the grant.
    always_comb begin
        arready = sel_ar & arready_s;
        rvalid  = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        if (sel_r) begin
            rvalid = rvalid_s;
            rid    = rid_s;
            rdata  = rdata_s;
            rresp  = rresp_s;
            rlast  = rlast_s;
        end else if (sel_err) begin
            rvalid = 1'b1;
            rid    = err_id;
            rresp  = 2'b10;
            rlast  = 1'b1;
        end
    end
endmodule

module axi_rd_arbiter #(
    parameter int NM        = 2,
    parameter int IDM_BITS  = 4,
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic          ACLK,
    input  logic          ARESET,
    axi_rd_arbiter_if.arb bus,
    output logic [NM-1:0] GRANT
);
    localparam int IW = $clog2(NM);

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
`endif

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] gidx, gidx_nxt, gidx_inc;
    logic [NM-1:0] grant_nxt;
    logic          win_vld;
    logic [IW-1:0] win_idx;

    // packed per-master views of the flattened buses
    logic [NM-1:0][IDM_BITS-1:0]  arid_m;
    logic [NM-1:0][ADDR_BITS-1:0] araddr_m;
    logic [NM-1:0][LEN_BITS-1:0]  arlen_m;
    logic [NM-1:0][2:0]           arsize_m;
    logic [NM-1:0][1:0]           arburst_m;
    logic [NM-1:0][IDM_BITS-1:0]  rid_m;
    logic [NM-1:0][DATA_BITS-1:0] rdata_m;
    logic [NM-1:0][1:0]           rresp_m;
    logic [NM-1:0]                rlast_m, rvalid_m, arready_m;

    assign arid_m    = bus.ARID_M;
    assign araddr_m  = bus.ARADDR_M;
    assign arlen_m   = bus.ARLEN_M;
    assign arsize_m  = bus.ARSIZE_M;
    assign arburst_m = bus.ARBURST_M;

    assign bus.RID_M     = rid_m;
    assign bus.RDATA_M   = rdata_m;
    assign bus.RRESP_M   = rresp_m;
    assign bus.RLAST_M   = rlast_m;
    assign bus.RVALID_M  = rvalid_m;
    assign bus.ARREADY_M = arready_m;

    logic [IDM_BITS-1:0] arid_g;
    logic                rready_g;
    logic                ar_hs, r_hs, st_addr, st_data, st_err;
    logic                to_hit;
    logic [IDM_BITS-1:0] err_id;

    // Only the master-side ID bits return; the index bits are implied by the grant.
    logic unused_rid_hi;
    assign unused_rid_hi = ^bus.RID_S[IDS_BITS-1:IDM_BITS];

    assign arid_g   = arid_m[gidx];
    assign rready_g = bus.RREADY_M[gidx];
    assign st_addr  = (state == S_ADDR);
    assign st_data  = (state == S_DATA);
    assign ar_hs    = st_addr & bus.ARREADY_S;
    assign r_hs     = st_data & bus.RVALID_S & rready_g;
    assign gidx_inc = (gidx == IW'(NM-1)) ? '0 : gidx + 1'b1;

    // First requester at or after ptr; scanning downward lets the nearest one win.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NM-1; i >= 0; i--) begin
            int            j;
            logic [IW-1:0] idx;
            j = int'(ptr) + i;
            if (j >= NM) j = j - NM;
            idx = IW'(j);
            if (bus.ARVALID_M[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] cnt;

    assign st_err = (state == S_ERR);
    // ERR is entered after TIMEOUT consecutive DATA cycles without an R handshake.
    assign to_hit = st_data & ~r_hs & (cnt == CW'(TIMEOUT-1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt    <= '0;
            err_id <= '0;
        end else if (ar_hs) begin
            cnt    <= '0;
            err_id <= arid_g;
        end else if (st_data) begin
            cnt <= r_hs ? '0 : cnt + CW'(1);
        end
    end
`else
    assign st_err = 1'b0;
    assign to_hit = 1'b0;
    assign err_id = '0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= S_IDLE;
            ptr   <= '0;
            gidx  <= '0;
            GRANT <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gidx  <= gidx_nxt;
            GRANT <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gidx_nxt  = gidx;
        grant_nxt = GRANT;
        unique case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_nxt = S_ADDR;
                    gidx_nxt  = win_idx;
                    grant_nxt = NM'(1) << win_idx;
                end
            end
            S_ADDR: begin
                if (ar_hs) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (r_hs && bus.RLAST_S) begin
                    state_nxt = S_IDLE;
                    ptr_nxt   = gidx_inc;
                    grant_nxt = '0;
                end else if (to_hit) begin
                    state_nxt = state_t'(2'd3);
                end
            end
            default: begin
                // ERR: the synthetic beat is consumed by the granted master
                if (rready_g) begin
                    state_nxt = S_IDLE;
                    ptr_nxt   = gidx_inc;
                    grant_nxt = '0;
                end
            end
        endcase
    end

    always_comb begin
        bus.ARVALID_S = st_addr;
        bus.ARID_S    = '0;
        bus.ARADDR_S  = '0;
        bus.ARLEN_S   = '0;
        bus.ARSIZE_S  = 3'd0;
        bus.ARBURST_S = 2'd0;
        bus.RREADY_S  = st_err | (st_data & rready_g);
        if (st_addr) begin
            bus.ARID_S    = IDS_BITS'({gidx, arid_g});
            bus.ARADDR_S  = araddr_m[gidx];
            bus.ARLEN_S   = arlen_m[gidx];
            bus.ARSIZE_S  = arsize_m[gidx];
            bus.ARBURST_S = arburst_m[gidx];
        end
    end

    for (genvar k = 0; k < NM; k++) begin : g_lane
        axi_rd_arbiter_lane #(
            .IDM_BITS  (IDM_BITS),
            .DATA_BITS (DATA_BITS)
        ) u_lane (
            .sel_ar    (st_addr & GRANT[k]),
            .sel_r     (st_data & GRANT[k]),
            .sel_err   (st_err & GRANT[k]),
            .arready_s (bus.ARREADY_S),
            .rvalid_s  (bus.RVALID_S),
            .rid_s     (bus.RID_S[IDM_BITS-1:0]),
            .rdata_s   (bus.RDATA_S),
            .rresp_s   (bus.RRESP_S),
            .rlast_s   (bus.RLAST_S),
            .err_id    (err_id),
            .arready   (arready_m[k]),
            .rvalid    (rvalid_m[k]),
            .rid       (rid_m[k]),
            .rdata     (rdata_m[k]),
            .rresp     (rresp_m[k]),
            .rlast     (rlast_m[k])
        );
    end
endmodule
